// File: rtl/spi_arb_pkg.sv
// Shared types and helpers for the SPI transaction arbiter.
package spi_arb_pkg;

  localparam int unsigned StateW = 2;

  typedef enum logic [StateW-1:0] {
    StIdle,
    StCmd,
    StBusy,
    StDone
  } arb_state_e;

  // Bits needed to count from 0 up to max_val inclusive.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val > 0) ? $clog2(max_val + 1) : 1;
  endfunction

endpackage

// File: rtl/spi_rr_picker.sv
// One-hot winner selection from a request vector.
// SPI_ARB_FIXED_PRIO_EN selects lowest-index-wins; otherwise round-robin from ptr_i.
module spi_rr_picker #(
  parameter int unsigned NumReq = 4,
  parameter int unsigned IdxW   = $clog2(NumReq)
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [IdxW-1:0]   ptr_i,
  output logic [NumReq-1:0] gnt_o,
  output logic [IdxW-1:0]   idx_o
);

  logic            any;
  logic [IdxW-1:0] lo_idx;

  // Descending scan so the last hit is the lowest set index.
  always_comb begin
    any    = 1'b0;
    lo_idx = '0;
    for (int i = NumReq - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        any    = 1'b1;
        lo_idx = IdxW'(i);
      end
    end
  end

`ifdef SPI_ARB_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr_i;
  assign idx_o      = lo_idx;
`else
  logic            hi_found;
  logic [IdxW-1:0] hi_idx;

  // Lowest request at or above the pointer; fall back to wrap-around.
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    for (int i = NumReq - 1; i >= 0; i--) begin
      if (req_i[i] && (i >= int'(ptr_i))) begin
        hi_found = 1'b1;
        hi_idx   = IdxW'(i);
      end
    end
  end

  assign idx_o = hi_found ? hi_idx : lo_idx;
`endif

  assign gnt_o = any ? (NumReq'(1) << idx_o) : '0;

endmodule

// File: rtl/spi_txn_arbiter.sv
// Shares one spi_master among NUM_REQ requesters; completion is the CS rising edge.
// Build option: SPI_ARB_FIXED_PRIO_EN switches arbitration to fixed lowest-index priority.
module spi_txn_arbiter
  import spi_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned CMD_HOLD = 10,
  parameter int unsigned TIMEOUT  = 1023
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_wr,
  input  logic [NUM_REQ-1:0]        req_rd,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_err,
  output logic                      spi_wr_cmd,
  output logic                      spi_rd_cmd,
  output logic [DATA_W-1:0]         mosi_data,
  input  logic                      spi_cs,
  input  logic [DATA_W-1:0]         miso_data
);

  localparam int unsigned IdxW  = $clog2(NUM_REQ);
  localparam int unsigned TmoW  = cnt_width(TIMEOUT);
  localparam int unsigned HoldW = cnt_width(CMD_HOLD);

  arb_state_e          state_q;
  logic [NUM_REQ-1:0]  win_q;
  logic                err_q;
  logic                cs_q;
  logic [TmoW-1:0]     tmo_cnt_q;
  logic [HoldW-1:0]    hold_cnt_q;
  logic [IdxW-1:0]     ptr;
  logic [NUM_REQ-1:0]  pick_gnt;
  logic [IdxW-1:0]     pick_idx;
  logic                sel_wr;
  logic                sel_rd;
  logic [DATA_W-1:0]   sel_data;

`ifdef SPI_ARB_FIXED_PRIO_EN
  logic unused_idx;
  assign ptr        = '0;
  assign unused_idx = ^pick_idx;
`else
  logic [IdxW-1:0] ptr_q;
  assign ptr = ptr_q;
`endif

  spi_rr_picker #(
    .NumReq (NUM_REQ),
    .IdxW   (IdxW)
  ) u_picker (
    .req_i (req_wr | req_rd),
    .ptr_i (ptr),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx)
  );

  assign sel_wr = |(req_wr & pick_gnt);
  assign sel_rd = |(req_rd & pick_gnt);

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_gnt[i]) sel_data = req_data[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      win_q      <= '0;
      err_q      <= 1'b0;
      cs_q       <= 1'b1;
      tmo_cnt_q  <= '0;
      hold_cnt_q <= '0;
`ifndef SPI_ARB_FIXED_PRIO_EN
      ptr_q      <= '0;
`endif
      gnt        <= '0;
      rsp_valid  <= '0;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
      spi_wr_cmd <= 1'b0;
      spi_rd_cmd <= 1'b0;
      mosi_data  <= '0;
    end else begin
      cs_q      <= spi_cs;
      gnt       <= '0;
      rsp_valid <= '0;
      rsp_err   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (|pick_gnt) begin
            gnt        <= pick_gnt;
            win_q      <= pick_gnt;
            spi_wr_cmd <= sel_wr;
            spi_rd_cmd <= sel_rd;
            mosi_data  <= sel_data;
            tmo_cnt_q  <= '0;
            hold_cnt_q <= '0;
            state_q    <= StCmd;
`ifndef SPI_ARB_FIXED_PRIO_EN
            ptr_q      <= (pick_idx == IdxW'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
`endif
          end
        end
        StCmd, StBusy: begin
          tmo_cnt_q <= tmo_cnt_q + 1'b1;
          // CS edges only count once the command phase is over.
          if (state_q == StBusy && !cs_q && spi_cs) begin
            rsp_data <= miso_data;
            err_q    <= 1'b0;
            state_q  <= StDone;
          end else if (tmo_cnt_q == TmoW'(TIMEOUT - 1)) begin
            rsp_data   <= '0;
            err_q      <= 1'b1;
            spi_wr_cmd <= 1'b0;
            spi_rd_cmd <= 1'b0;
            state_q    <= StDone;
          end else if (state_q == StCmd) begin
            hold_cnt_q <= hold_cnt_q + 1'b1;
            if (hold_cnt_q == HoldW'(CMD_HOLD - 1)) begin
              spi_wr_cmd <= 1'b0;
              spi_rd_cmd <= 1'b0;
              state_q    <= StBusy;
            end
          end
        end
        StDone: begin
          rsp_valid <= win_q;
          rsp_err   <= err_q;
          state_q   <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
